// File: rtl/percept_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART tx line among N requesters.
// Define PERCEPT_TX_ADDR_EN to precede each data byte with the winner's index byte.
module percept_tx_arbiter #(
   parameter int unsigned N            = 256,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic           clk,
   input  logic           nRst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] data,
   output logic [N-1:0]   ack,
   output logic           busy,
   output logic           tx
);

   localparam int unsigned IDX_W = $clog2(N);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [7:0]         shift_q, shift_d;
   logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [N-1:0]       ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               tx_q, tx_d;
`ifdef PERCEPT_TX_ADDR_EN
   logic [7:0]         next_q, next_d;
   logic               byte_sel_q, byte_sel_d;
`endif

   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   cand;
   logic               any;
   logic               bit_end;

   // Scan upward from last+1; the index width makes the wrap from N-1 to 0 free.
   always_comb begin
      win  = last_q;
      any  = 1'b0;
      cand = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IDX_W'(last_q + i);
         if (!any && req[cand]) begin
            win = cand;
            any = 1'b1;
         end
      end
   end

   assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      shift_d   = shift_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      ack_d     = '0;
      busy_d    = busy_q;
      tx_d      = tx_q;
`ifdef PERCEPT_TX_ADDR_EN
      next_d     = next_q;
      byte_sel_d = byte_sel_q;
`endif
      if (state_q != S_IDLE) begin
         clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (any) begin
               state_d    = S_START;
               last_d     = win;
               ack_d[win] = 1'b1;
               busy_d     = 1'b1;
               tx_d       = 1'b0;
`ifdef PERCEPT_TX_ADDR_EN
               shift_d    = 8'(win);
               next_d     = data[{win, 3'b000} +: 8];
               byte_sel_d = 1'b0;
`else
               shift_d    = data[{win, 3'b000} +: 8];
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
`ifdef PERCEPT_TX_ADDR_EN
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  shift_d    = next_q;
                  state_d    = S_START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
               end
`else
               state_d = S_IDLE;
               busy_d  = 1'b0;
               tx_d    = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= S_IDLE;
         last_q     <= IDX_W'(N - 1);
         shift_q    <= '0;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         tx_q       <= 1'b1;
`ifdef PERCEPT_TX_ADDR_EN
         next_q     <= '0;
         byte_sel_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         shift_q    <= shift_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         tx_q       <= tx_d;
`ifdef PERCEPT_TX_ADDR_EN
         next_q     <= next_d;
         byte_sel_q <= byte_sel_d;
`endif
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;
   assign tx   = tx_q;

endmodule

// File: tb/tb_percept_tx_arbiter.sv
// Bench for percept_tx_arbiter: directed scenarios plus randomized round-robin traffic
// checked against a behavioural grant/frame model. Honours PERCEPT_TX_ADDR_EN.
module tb_percept_tx_arbiter;

   localparam int N   = 256;
   localparam int CPB = 4;
`ifdef PERCEPT_TX_ADDR_EN
   localparam int B = 2;
`else
   localparam int B = 1;
`endif
   localparam int FRAME = 10 * CPB * B;

   logic           clk = 1'b0;
   logic           nRst;
   logic [N-1:0]   req;
   logic [8*N-1:0] data;
   logic [N-1:0]   ack;
   logic           busy;
   logic           tx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int model_last = N - 1;
   int last_ack_cyc = 0;
   logic [7:0] byte_mem [N];

   percept_tx_arbiter #(.N(N), .CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .nRst (nRst),
      .req  (req),
      .data (data),
      .ack  (ack),
      .busy (busy),
      .tx   (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Round-robin rule: first requester found scanning upward from last+1, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         if (r[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int idx, input logic [7:0] val);
      byte_mem[idx]      = val;
      data[8*idx +: 8]   = val;
      req[idx]           = 1'b1;
   endtask

   // Waits for a grant, checks it against exp_idx, optionally checks the whole frame.
   // Returns at the first cycle after the frame when full is set.
   task automatic expect_grant(input int exp_idx, input bit drop, input bit full, input bit b2b);
      int got_idx;
      int bits [20];
      logic [7:0] bytes [2];
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (|ack) begin
            seen = 1'b1;
            break;
         end
      end
      check("ack_seen", 32'(seen), 32'd1);
      if (!seen) return;
      got_idx = -1;
      for (int i = 0; i < N; i++) if (ack[i]) got_idx = i;
      check("ack_onehot", 32'($countones(ack)), 32'd1);
      check("grant_idx", got_idx, exp_idx);
      check("busy_at_ack", 32'(busy), 32'd1);
      if (b2b) check("ack_spacing", cyc - last_ack_cyc, FRAME + 1);
      last_ack_cyc = cyc;
      model_last = exp_idx;
      if (drop) req[exp_idx] = 1'b0;
      if (!full) return;
`ifdef PERCEPT_TX_ADDR_EN
      bytes[0] = 8'(exp_idx);
      bytes[1] = byte_mem[exp_idx];
`else
      bytes[0] = byte_mem[exp_idx];
      bytes[1] = 8'h00;
`endif
      for (int f = 0; f < B; f++) begin
         bits[10*f] = 0;
         for (int b = 0; b < 8; b++) bits[10*f + 1 + b] = int'(bytes[f][b]);
         bits[10*f + 9] = 1;
      end
      for (int s = 0; s < FRAME; s++) begin
         if (s > 0) @(negedge clk);
         check("tx_bit", 32'(tx), bits[s / CPB]);
         if (s % CPB == 0) check("busy_frame", 32'(busy), 32'd1);
         if (s == 1) check("ack_width", 32'(|ack), 32'd0);
      end
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_tx", 32'(tx), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRst = 1'b0;
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(|ack), 32'd0);
      model_last = N - 1;
      @(negedge clk);
      nRst = 1'b1;
   endtask

   initial begin
      int req_cyc, acks, lows, busys, j;
      nRst = 1'b0;
      req  = '0;
      data = '0;
      for (int i = 0; i < N; i++) byte_mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      do_reset();

      // Single request, ack latency of one cycle.
      @(negedge clk);
      set_req(5, 8'hA5);
      req_cyc = cyc;
      expect_grant(5, 1'b1, 1'b1, 1'b0);
      check("ack_latency", last_ack_cyc - req_cyc, 1);

      // Two held requesters alternate.
      do_reset();
      set_req(3, 8'h3C);
      set_req(200, 8'hC8);
      expect_grant(3, 1'b0, 1'b1, 1'b0);
      expect_grant(200, 1'b0, 1'b1, 1'b1);
      expect_grant(3, 1'b0, 1'b1, 1'b1);
      expect_grant(200, 1'b0, 1'b1, 1'b1);

      // Wrap-around after a grant to 255.
      req = '0;
      set_req(255, 8'h81);
      expect_grant(255, 1'b1, 1'b1, 1'b0);
      set_req(0, 8'h0F);
      set_req(254, 8'hE7);
      expect_grant(0, 1'b1, 1'b1, 1'b1);
      expect_grant(254, 1'b1, 1'b1, 1'b1);

      // Randomized traffic against the round-robin model.
      for (int it = 0; it < 30; it++) begin
         for (int a = 0; a < $urandom_range(0, 2); a++) begin
            j = $urandom_range(0, N - 1);
            if (!req[j]) set_req(j, 8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
         if (req == '0) set_req($urandom_range(0, N - 1), 8'($urandom_range(0, 255)));
         expect_grant(rr_pick(req, model_last), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      end

      // Reset in the middle of a frame, then a full frame for the held request.
      req = '0;
      @(negedge clk);
      set_req(7, 8'h5A);
      expect_grant(7, 1'b0, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      #2;
      nRst = 1'b0;
      #1;
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      model_last = N - 1;
      @(negedge clk);
      nRst = 1'b1;
      expect_grant(7, 1'b1, 1'b1, 1'b0);

      // Request raised and withdrawn while busy is never granted.
      @(negedge clk);
      set_req(20, 8'h99);
      expect_grant(20, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      set_req(9, 8'h42);
      repeat (10) @(negedge clk);
      req[9] = 1'b0;
      for (int i = 0; i < 2 * FRAME && busy; i++) @(negedge clk);
      check("busy_drops", 32'(busy), 32'd0);
      acks = 0;
      lows = 0;
      busys = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (|ack) acks++;
         if (!tx) lows++;
         if (busy) busys++;
      end
      check("withdrawn_ack", acks, 0);
      check("withdrawn_tx", lows, 0);
      check("withdrawn_busy", busys, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
